// File: rtl/dma_packet_rx.sv
// Byte-serial DMA packet receiver: decodes upload / enqueue / read / discard packets into strobed outputs.
// Optional inter-byte timeout abort is enabled by defining DMA_PACKET_RX_TIMEOUT_EN.
module dma_packet_rx #(
   parameter int unsigned TILE_BITS  = 288,
   parameter int unsigned ADDR_BITS  = 16,
   parameter int unsigned INSTR_BITS = 16,
   parameter int unsigned QADDR_BITS = 8
`ifdef DMA_PACKET_RX_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  rx_interrupt_i,
   input  logic [7:0]            rx_data_i,
   output logic                  mem_read_result_stb_o,
   output logic [TILE_BITS-1:0]  mem_read_result_matrix_tile_o,
   output logic                  mem_read_result_last_o,
   output logic                  upload_program_stb_o,
   output logic [ADDR_BITS-1:0]  upload_program_instr_addr_o,
   output logic [INSTR_BITS-1:0] upload_program_instr_dat_o,
   output logic                  enqueue_program_stb_o,
   output logic [QADDR_BITS-1:0] enqueue_program_addr_o,
   output logic                  rx_busy_o,
   output logic                  rx_error_stb_o,
   output logic [1:0]            rx_error_code_o
);

   localparam logic [15:0] TILE_BYTES  = 16'(TILE_BITS / 8);
   localparam logic [15:0] ADDR_BYTES  = 16'(ADDR_BITS / 8);
   localparam logic [15:0] INSTR_BYTES = 16'(INSTR_BITS / 8);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_UPLOAD  = 3'd1,
      S_ENQUEUE = 3'd2,
      S_READ    = 3'd3,
      S_DISCARD = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [5:0]            len_q, len_d;
   logic [15:0]           byte_cnt_q, byte_cnt_d;
   logic [15:0]           unit_cnt_q, unit_cnt_d;
   logic [5:0]            tile_cnt_q, tile_cnt_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [INSTR_BITS-1:0] instr_q, instr_d;
   logic [TILE_BITS-1:0]  tile_q, tile_d;
   logic                  rd_stb_q, rd_stb_d;
   logic                  rd_last_q, rd_last_d;
   logic                  up_stb_q, up_stb_d;
   logic [ADDR_BITS-1:0]  up_addr_q, up_addr_d;
   logic [INSTR_BITS-1:0] up_dat_q, up_dat_d;
   logic                  enq_stb_q, enq_stb_d;
   logic [QADDR_BITS-1:0] enq_addr_q, enq_addr_d;
   logic                  busy_q, busy_d;
   logic                  err_stb_q, err_stb_d;
   logic [1:0]            err_code_q, err_code_d;

   logic                  expired_s;
   logic [ADDR_BITS-1:0]  addr_shift_s;
   logic [INSTR_BITS-1:0] instr_shift_s;
   logic [TILE_BITS-1:0]  tile_shift_s;
   logic [5:0]            last_tile_s;

   // Casting the concatenation down keeps the LSBs, i.e. the new byte enters at the bottom.
   assign addr_shift_s  = ADDR_BITS'({addr_q, rx_data_i});
   assign instr_shift_s = INSTR_BITS'({instr_q, rx_data_i});
   assign tile_shift_s  = TILE_BITS'({tile_q, rx_data_i});
   assign last_tile_s   = (len_q == 6'd0) ? 6'd0 : (len_q - 6'd1);

`ifdef DMA_PACKET_RX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] idle_cnt_q, idle_cnt_d;

   assign expired_s = (state_q != S_IDLE) && (idle_cnt_q == TW'(TIMEOUT_CYC));

   // Idle counter: restarts on every byte and whenever the packet ends.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if ((state_d == S_IDLE) || rx_interrupt_i) begin
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + {{(TW-1){1'b0}}, 1'b1};
      end
   end

   // Idle counter register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   assign expired_s = 1'b0;
`endif

   // Next-state and output decode; an expiring timeout frees the FSM so a coincident byte is a header.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      unit_cnt_d = unit_cnt_q;
      tile_cnt_d = tile_cnt_q;
      addr_d     = addr_q;
      instr_d    = instr_q;
      tile_d     = tile_q;
      rd_stb_d   = 1'b0;
      rd_last_d  = rd_last_q;
      up_stb_d   = 1'b0;
      up_addr_d  = up_addr_q;
      up_dat_d   = up_dat_q;
      enq_stb_d  = 1'b0;
      enq_addr_d = enq_addr_q;
      err_stb_d  = 1'b0;
      err_code_d = err_code_q;

      if (expired_s) begin
         state_d    = S_IDLE;
         err_stb_d  = 1'b1;
         err_code_d = 2'd2;
      end else begin
         err_stb_d  = 1'b0;
      end

      if (rx_interrupt_i && ((state_q == S_IDLE) || expired_s)) begin
         len_d      = rx_data_i[5:0];
         byte_cnt_d = 16'd0;
         unit_cnt_d = 16'd0;
         tile_cnt_d = 6'd0;
         case (rx_data_i[7:6])
            2'd0: begin
               if ({10'd0, rx_data_i[5:0]} < ADDR_BYTES) begin
                  state_d    = S_IDLE;
                  err_stb_d  = 1'b1;
                  err_code_d = 2'd1;
               end else begin
                  state_d    = S_UPLOAD;
               end
            end
            2'd1:    state_d = S_ENQUEUE;
            2'd2:    state_d = S_READ;
            default: begin
               if (rx_data_i[5:0] == 6'd0) begin
                  state_d    = S_IDLE;
                  err_stb_d  = 1'b1;
                  err_code_d = 2'd0;
               end else begin
                  state_d    = S_DISCARD;
               end
            end
         endcase
      end else if (rx_interrupt_i) begin
         case (state_q)
            S_UPLOAD: begin
               byte_cnt_d = byte_cnt_q + 16'd1;
               if (byte_cnt_q < ADDR_BYTES) begin
                  addr_d = addr_shift_s;
               end else begin
                  instr_d = instr_shift_s;
                  if (unit_cnt_q == INSTR_BYTES - 16'd1) begin
                     up_stb_d   = 1'b1;
                     up_dat_d   = instr_shift_s;
                     up_addr_d  = addr_q;
                     addr_d     = addr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                     unit_cnt_d = 16'd0;
                  end else begin
                     unit_cnt_d = unit_cnt_q + 16'd1;
                  end
               end
               // A final byte that does not close a word leaves a dropped partial instruction.
               if (byte_cnt_q == ({10'd0, len_q} - 16'd1)) begin
                  state_d = S_IDLE;
                  if ((byte_cnt_q >= ADDR_BYTES) && (unit_cnt_q != INSTR_BYTES - 16'd1)) begin
                     err_stb_d  = 1'b1;
                     err_code_d = 2'd1;
                  end else begin
                     err_stb_d  = 1'b0;
                  end
               end else begin
                  state_d = S_UPLOAD;
               end
            end
            S_ENQUEUE: begin
               enq_addr_d = rx_data_i[QADDR_BITS-1:0];
               enq_stb_d  = 1'b1;
               state_d    = S_IDLE;
            end
            S_READ: begin
               tile_d = tile_shift_s;
               if (unit_cnt_q == TILE_BYTES - 16'd1) begin
                  rd_stb_d   = 1'b1;
                  unit_cnt_d = 16'd0;
                  tile_cnt_d = tile_cnt_q + 6'd1;
                  if (tile_cnt_q == last_tile_s) begin
                     rd_last_d = 1'b1;
                     state_d   = S_IDLE;
                  end else begin
                     rd_last_d = 1'b0;
                  end
               end else begin
                  unit_cnt_d = unit_cnt_q + 16'd1;
               end
            end
            S_DISCARD: begin
               byte_cnt_d = byte_cnt_q + 16'd1;
               if (byte_cnt_q == ({10'd0, len_q} - 16'd1)) begin
                  state_d    = S_IDLE;
                  err_stb_d  = 1'b1;
                  err_code_d = 2'd0;
               end else begin
                  state_d    = S_DISCARD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         byte_cnt_d = byte_cnt_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= S_IDLE;
         len_q      <= 6'd0;
         byte_cnt_q <= 16'd0;
         unit_cnt_q <= 16'd0;
         tile_cnt_q <= 6'd0;
         addr_q     <= '0;
         instr_q    <= '0;
         tile_q     <= '0;
         rd_stb_q   <= 1'b0;
         rd_last_q  <= 1'b0;
         up_stb_q   <= 1'b0;
         up_addr_q  <= '0;
         up_dat_q   <= '0;
         enq_stb_q  <= 1'b0;
         enq_addr_q <= '0;
         busy_q     <= 1'b0;
         err_stb_q  <= 1'b0;
         err_code_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         byte_cnt_q <= byte_cnt_d;
         unit_cnt_q <= unit_cnt_d;
         tile_cnt_q <= tile_cnt_d;
         addr_q     <= addr_d;
         instr_q    <= instr_d;
         tile_q     <= tile_d;
         rd_stb_q   <= rd_stb_d;
         rd_last_q  <= rd_last_d;
         up_stb_q   <= up_stb_d;
         up_addr_q  <= up_addr_d;
         up_dat_q   <= up_dat_d;
         enq_stb_q  <= enq_stb_d;
         enq_addr_q <= enq_addr_d;
         busy_q     <= busy_d;
         err_stb_q  <= err_stb_d;
         err_code_q <= err_code_d;
      end
   end

   assign mem_read_result_stb_o         = rd_stb_q;
   assign mem_read_result_matrix_tile_o = tile_q;
   assign mem_read_result_last_o        = rd_last_q;
   assign upload_program_stb_o          = up_stb_q;
   assign upload_program_instr_addr_o   = up_addr_q;
   assign upload_program_instr_dat_o    = up_dat_q;
   assign enqueue_program_stb_o         = enq_stb_q;
   assign enqueue_program_addr_o        = enq_addr_q;
   assign rx_busy_o                     = busy_q;
   assign rx_error_stb_o                = err_stb_q;
   assign rx_error_code_o               = err_code_q;

endmodule

// File: tb/tb_dma_packet_rx.sv
// Scoreboard bench for dma_packet_rx: directed packets plus randomized packets checked
// against a packet-level reference model; a negedge monitor pops expectations on each strobe.
module tb_dma_packet_rx;

   localparam int TBYTES = 36;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          rx_int;
   logic [7:0]    rx_data;
   logic          rd_stb, rd_last, up_stb, enq_stb, busy, err_stb;
   logic [287:0]  tile;
   logic [15:0]   up_addr, up_dat;
   logic [7:0]    enq_addr;
   logic [1:0]    err_code;

   int checks = 0;
   int errors = 0;

   logic [31:0]  exp_up[$];
   logic [7:0]   exp_enq[$];
   logic [288:0] exp_rd[$];
   logic [1:0]   exp_err[$];
   logic [7:0]   pkt[$];

   always #5 clk = ~clk;

   dma_packet_rx dut (
      .clk_i                         (clk),
      .reset_ni                      (reset_n),
      .rx_interrupt_i                (rx_int),
      .rx_data_i                     (rx_data),
      .mem_read_result_stb_o         (rd_stb),
      .mem_read_result_matrix_tile_o (tile),
      .mem_read_result_last_o        (rd_last),
      .upload_program_stb_o          (up_stb),
      .upload_program_instr_addr_o   (up_addr),
      .upload_program_instr_dat_o    (up_dat),
      .enqueue_program_stb_o         (enq_stb),
      .enqueue_program_addr_o        (enq_addr),
      .rx_busy_o                     (busy),
      .rx_error_stb_o                (err_stb),
      .rx_error_code_o               (err_code)
   );

   task automatic chk(input string nm, input logic [288:0] act, input logic [288:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      errors++;
      $display("FAIL %s: got a strobe, expected none queued", nm);
   endtask

   // Monitor: every strobe pops its own expectation queue.
   always @(negedge clk) begin
      if (reset_n) begin
         if (rd_stb || up_stb || enq_stb || err_stb)
            chk("single_strobe", 289'(int'(rd_stb) + int'(up_stb) + int'(enq_stb) + int'(err_stb)), 289'(1));
         if (up_stb) begin
            checks++;
            if (exp_up.size() == 0) unexpected("upload_unexpected");
            else chk("upload", 289'({up_addr, up_dat}), 289'(exp_up.pop_front()));
         end
         if (enq_stb) begin
            checks++;
            if (exp_enq.size() == 0) unexpected("enqueue_unexpected");
            else chk("enqueue", 289'(enq_addr), 289'(exp_enq.pop_front()));
         end
         if (rd_stb) begin
            checks++;
            if (exp_rd.size() == 0) unexpected("read_unexpected");
            else chk("read_tile", {rd_last, tile}, exp_rd.pop_front());
         end
         if (err_stb) begin
            checks++;
            if (exp_err.size() == 0) unexpected("error_unexpected");
            else chk("error_code", 289'(err_code), 289'(exp_err.pop_front()));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_int  = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_int  = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic send_pkt(input bit gaps);
      foreach (pkt[i]) begin
         send_byte(pkt[i]);
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic drain(input string nm);
      repeat (4) @(negedge clk);
      chk({nm, "_up_left"},  289'(exp_up.size()),  289'(0));
      chk({nm, "_enq_left"}, 289'(exp_enq.size()), 289'(0));
      chk({nm, "_rd_left"},  289'(exp_rd.size()),  289'(0));
      chk({nm, "_err_left"}, 289'(exp_err.size()), 289'(0));
      chk({nm, "_busy"},     289'(busy),           289'(0));
   endtask

   // Reference model: derives the whole packet's expected strobes from the packet rules.
   task automatic model_pkt();
      int typ, len, nw, tiles;
      logic [15:0]  a;
      logic [287:0] t;
      typ = int'(pkt[0][7:6]);
      len = int'(pkt[0][5:0]);
      case (typ)
         0: begin
            if (len < 2) exp_err.push_back(2'd1);
            else begin
               a  = {pkt[1], pkt[2]};
               nw = (len - 2) / 2;
               for (int w = 0; w < nw; w++)
                  exp_up.push_back({16'(a + 16'(w)), pkt[3 + 2*w], pkt[4 + 2*w]});
               if (((len - 2) % 2) != 0) exp_err.push_back(2'd1);
            end
         end
         1: exp_enq.push_back(pkt[1]);
         2: begin
            tiles = (len == 0) ? 1 : len;
            for (int k = 0; k < tiles; k++) begin
               for (int b = 0; b < TBYTES; b++) t[287 - 8*b -: 8] = pkt[1 + k*TBYTES + b];
               exp_rd.push_back({(k == tiles - 1), t});
            end
         end
         default: exp_err.push_back(2'd0);
      endcase
   endtask

   task automatic make_pkt(input int typ, input int len);
      int n;
      pkt.delete();
      pkt.push_back({2'(typ), 6'(len)});
      case (typ)
         0:       n = (len >= 2) ? len : 0;
         1:       n = 1;
         2:       n = ((len == 0) ? 1 : len) * TBYTES;
         default: n = len;
      endcase
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
   endtask

   initial begin
      logic [287:0] t;
      reset_n = 1'b0;
      rx_int  = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset_outputs", 289'({rd_stb, rd_last, up_stb, enq_stb, busy, err_stb, err_code, up_addr, up_dat, enq_addr}), 289'(0));
      chk("reset_tile", 289'(tile), 289'(0));

      // Upload of two instructions.
      exp_up.push_back({16'h0010, 16'h1234});
      exp_up.push_back({16'h0011, 16'h5678});
      pkt = '{8'h06, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78};
      send_pkt(1'b0);
      drain("upload");

      // Enqueue: busy for exactly the one gap between header and payload.
      exp_enq.push_back(8'h2A);
      send_byte(8'h40);
      chk("enq_busy_mid", 289'(busy), 289'(1));
      send_byte(8'h2A);
      chk("enq_busy_end", 289'(busy), 289'(0));
      drain("enqueue");

      // Two-tile read with payload bytes 0..71.
      pkt.delete();
      pkt.push_back(8'h82);
      for (int i = 0; i < 72; i++) pkt.push_back(8'(i));
      for (int k = 0; k < 2; k++) begin
         for (int b = 0; b < TBYTES; b++) t[287 - 8*b -: 8] = 8'(k*TBYTES + b);
         exp_rd.push_back({(k == 1), t});
      end
      send_pkt(1'b1);
      drain("read");
      chk("read_tile_hold_msb", 289'(tile[287:280]), 289'(8'h24));
      chk("read_tile_hold_lsb", 289'(tile[7:0]),     289'(8'h47));

      // Discard then enqueue.
      exp_err.push_back(2'd0);
      exp_enq.push_back(8'h01);
      pkt = '{8'hC2, 8'hAA, 8'hBB, 8'h40, 8'h01};
      send_pkt(1'b0);
      drain("discard");

      // Upload with trailing partial word.
      exp_up.push_back({16'h0020, 16'hABCD});
      exp_err.push_back(2'd1);
      pkt = '{8'h05, 8'h00, 8'h20, 8'hAB, 8'hCD, 8'hEF};
      send_pkt(1'b1);
      drain("upload_partial");
      chk("err_code_hold", 289'(err_code), 289'(1));

      // Address wrap, short upload header, empty discard header, zero-length read.
      exp_up.push_back({16'hFFFF, 16'h1111});
      exp_up.push_back({16'h0000, 16'h2222});
      pkt = '{8'h06, 8'hFF, 8'hFF, 8'h11, 8'h11, 8'h22, 8'h22};
      send_pkt(1'b0);
      exp_err.push_back(2'd1);
      send_byte(8'h01);
      chk("short_upload_busy", 289'(busy), 289'(0));
      exp_err.push_back(2'd0);
      send_byte(8'hC0);
      make_pkt(2, 0);
      model_pkt();
      send_pkt(1'b0);
      drain("boundaries");

      // Reset in the middle of a read burst.
      pkt.delete();
      pkt.push_back(8'h82);
      for (int i = 0; i < 40; i++) pkt.push_back(8'($urandom));
      for (int b = 0; b < TBYTES; b++) t[287 - 8*b -: 8] = pkt[1 + b];
      exp_rd.push_back({1'b0, t});
      send_pkt(1'b0);
      chk("mid_read_busy", 289'(busy), 289'(1));
      reset_n = 1'b0;
      #1;
      chk("midreset_outputs", 289'({rd_stb, rd_last, up_stb, enq_stb, busy, err_stb, err_code, up_addr, up_dat, enq_addr}), 289'(0));
      chk("midreset_tile", 289'(tile), 289'(0));
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      exp_enq.push_back(8'h77);
      pkt = '{8'h40, 8'h77};
      send_pkt(1'b0);
      drain("after_reset");

      // Randomized packets against the reference model.
      for (int p = 0; p < 40; p++) begin
         int typ, len;
         typ = $urandom_range(0, 3);
         case (typ)
            0:       len = $urandom_range(0, 12);
            1:       len = $urandom_range(0, 63);
            2:       len = $urandom_range(0, 2);
            default: len = $urandom_range(0, 5);
         endcase
         make_pkt(typ, len);
         model_pkt();
         send_pkt($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1);
   end

endmodule
